muldiv_iter: RTL

Iterative 32-bit unsigned multiply/divide unit feeding the register file write port. Accepts a single operation with both source operands and a destination index, computes the result over a fixed 32-step sequence, then presents a one-cycle write strobe with the result and destination index. These connect directly to the register file's `we_i`, `datord_i` and `rd_i` inputs. One operation is in flight at a time; `busy_o` stalls the issuing logic.

---
 rtl/muldiv_iter_if.sv | 25 ++
 rtl/muldiv_iter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_if.sv
// Issue/writeback bundle between the issuing logic, muldiv_iter and the register file write port.
// The issuer uses the master view; the unit uses the slave view.
interface muldiv_iter_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [4:0]      rd_i;
    logic            busy_o;
    logic            we_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] datord_o;

    modport master (
        output start_i, op_i, rs1_data_i, rs2_data_i, rd_i,
        input  busy_o, we_o, rd_o, datord_o
    );

    modport slave (
        input  start_i, op_i, rs1_data_i, rs2_data_i, rd_i,
        output busy_o, we_o, rd_o, datord_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU: one operation in flight, XLEN steps, then a
// single-cycle register-file write strobe.
module muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    muldiv_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU} op_t;

    localparam logic [5:0] LAST_STEP = 6'(XLEN - 1);

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            we_q, we_d;
    logic [4:0]      rdo_q, rdo_d;
    logic [XLEN-1:0] res_q, res_d;

    logic            accept;
    logic            is_div;
    logic            div_zero;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_tr;
    logic [XLEN-1:0] step_acc;
    logic [XLEN-1:0] step_lo;
    logic [XLEN-1:0] final_res;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            rdo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            rdo_q   <= rdo_d;
            res_q   <= res_d;
        end
    end

    // {acc, lo} is the 2*XLEN product for multiply, and {remainder, shifting dividend/quotient}
    // for divide; the XLEN+1-bit trial remainder only exists combinationally, since a
    // restored remainder is always below the divisor and fits in XLEN bits.
    always_comb begin
        is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);
        div_zero = (b_q == '0);
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_sh   = {acc_q, lo_q[XLEN-1]};
        div_tr   = div_sh - {1'b0, b_q};

        if (is_div) begin
            step_acc = div_tr[XLEN] ? div_sh[XLEN-1:0] : div_tr[XLEN-1:0];
            step_lo  = {lo_q[XLEN-2:0], ~div_tr[XLEN]};
        end else begin
            step_acc = mul_sum[XLEN:1];
            step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        unique case (op_q)
            OP_MUL:   final_res = step_lo;
            OP_MULHU: final_res = step_acc;
            OP_DIVU:  final_res = div_zero ? '1 : step_lo;
            OP_REMU:  final_res = div_zero ? a_q : step_acc;
            default:  final_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        rdo_d   = '0;
        res_d   = '0;

        // DONE also accepts, so a held start_i issues every 33 cycles with no idle bubble.
        accept = bus.start_i && (state_q != CALC);

        unique case (state_q)
            IDLE: state_d = IDLE;
            CALC: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    we_d    = (rd_q != '0);
                    rdo_d   = (rd_q != '0) ? rd_q : '0;
                    res_d   = (rd_q != '0) ? final_res : '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = CALC;
            op_d    = op_t'(bus.op_i);
            cnt_d   = '0;
            rd_d    = bus.rd_i;
            a_d     = bus.rs1_data_i;
            b_d     = bus.rs2_data_i;
            acc_d   = '0;
            lo_d    = bus.op_i[1] ? bus.rs1_data_i : bus.rs2_data_i;
        end

        busy_d = (state_d != IDLE);
    end

    assign bus.busy_o   = busy_q;
    assign bus.we_o     = we_q;
    assign bus.rd_o     = rdo_q;
    assign bus.datord_o = res_q;
endmodule
